// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, keeps at most one imem request in
// flight and drives the IF/ID register read by decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] Mtvec,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state;
    logic [31:0] pcf;
    logic [31:0] pcf_plus4;
    logic [31:0] buffer;
    logic [31:0] target;
    logic        kill;
    logic        redirect;
    logic        accept;
    logic        load_buf;

    assign pcf_plus4 = pcf + 32'd4;
    assign redirect  = (PCSrcE != 2'b00);

    // NOTE: every path assigns target, so the default arm keeps this purely combinational.
    always_comb begin
        case (PCSrcE)
            2'b01:   target = PCTargetE;
            2'b10:   target = ALUResultE & ~32'h1;
            2'b11:   target = Mtvec & ~32'h3;
            default: target = pcf;
        endcase
    end

    // A live response taken by an unstalled decode immediately chains the next fetch.
    assign accept   = (state == WAIT) && imem_rvalid && !kill && !redirect && !StallD;
    assign load_buf = (state == HOLD) && !StallD && !redirect;

    assign imem_req  = ((state == IDLE) && !redirect) || accept;
    assign imem_addr = (state == WAIT) ? pcf_plus4 : pcf;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pcf    <= RESET_PC;
            kill   <= 1'b0;
            buffer <= 32'd0;
        end else begin
            if (redirect)
                pcf <= target;
            case (state)
                IDLE: begin
                    if (!redirect)
                        state <= WAIT;
                end
                WAIT: begin
                    if (!imem_rvalid) begin
                        if (redirect)
                            kill <= 1'b1;
                    end else if (kill || redirect) begin
                        // The in-flight response belongs to a squashed path.
                        kill  <= 1'b0;
                        state <= IDLE;
                    end else if (!StallD) begin
                        pcf <= pcf_plus4;
                    end else begin
                        buffer <= imem_rdata;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        state <= IDLE;
                    end else if (!StallD) begin
                        pcf   <= pcf_plus4;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flush beats stall; otherwise an unstalled decode with nothing new sees a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (redirect) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (accept) begin
            InstrD   <= imem_rdata;
            PCD      <= pcf;
            PCPlus4D <= pcf_plus4;
            ValidD   <= 1'b1;
        end else if (load_buf) begin
            InstrD   <= buffer;
            PCD      <= pcf;
            PCPlus4D <= pcf_plus4;
            ValidD   <= 1'b1;
        end else if (!StallD) begin
            ValidD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level front-end model and a
// variable-latency memory, plus directed redirect/stall/reset scenarios.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req, imem_rvalid, StallD, ValidD;
    logic [31:0] imem_addr, imem_rdata, PCTargetE, ALUResultE, Mtvec;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic [1:0]  PCSrcE;

    logic        req2, rv2, valid2;
    logic [31:0] addr2, rd2, instr2, pcd2, pcp42;

    fetch_stage dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .StallD(StallD), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .ALUResultE(ALUResultE), .Mtvec(Mtvec),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_stage #(.RESET_PC(RPC2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .imem_req(req2), .imem_addr(addr2),
        .imem_rvalid(rv2), .imem_rdata(rd2),
        .StallD(1'b0), .PCSrcE(2'b00),
        .PCTargetE(32'd0), .ALUResultE(32'd0), .Mtvec(32'd0),
        .InstrD(instr2), .PCD(pcd2), .PCPlus4D(pcp42), .ValidD(valid2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Reference model: where the next fetch goes, whether a request is in flight
    // (and whether it was squashed), a parked instruction, and the IF/ID contents.
    logic [31:0] m_pc, m_buf, m_instr, m_pcd, m_pcp4;
    logic        m_out, m_stale, m_held, m_valid;

    // Memory environment: one response per request after 1..N cycles.
    logic        mem_busy, late_junk;
    int          mem_cnt, lat_min, lat_max;
    logic [31:0] mem_addr;
    logic        req2_q;
    logic [31:0] addr2_q;

    int          cyc, early_n;
    logic        req_seen;
    logic [31:0] first_addr;

    task automatic model_reset();
        m_pc = 32'd0; m_buf = 32'd0; m_instr = NOP; m_pcd = 32'd0; m_pcp4 = 32'd0;
        m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0; m_valid = 1'b0;
        mem_busy = 1'b0; mem_cnt = 0; cyc = 0;
    endtask

    // Called at posedge+1; drives one cycle, checks it, advances the model, ends at next posedge+1.
    task automatic do_cycle(input logic st, input logic [1:0] src, input logic [31:0] tgt,
                            input logic [31:0] alu, input logic [31:0] mt);
        logic        redir, e_req;
        logic [31:0] t, e_addr, e_pc;
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (late_junk) begin
            imem_rvalid = 1'b1;
            late_junk   = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mdata(mem_addr);
                mem_busy    = 1'b0;
            end
        end
        rv2 = req2_q;
        rd2 = mdata(addr2_q);
        StallD = st; PCSrcE = src; PCTargetE = tgt; ALUResultE = alu; Mtvec = mt;
        #3;
        redir = (src != 2'b00);
        case (src)
            2'b01:   t = tgt;
            2'b10:   t = alu & ~32'h1;
            2'b11:   t = mt & ~32'h3;
            default: t = m_pc;
        endcase
        e_req  = 1'b0;
        e_addr = m_pc;
        if (!m_held && !m_out)
            e_req = !redir;
        else if (m_out && imem_rvalid && !m_stale && !redir && !st) begin
            e_req  = 1'b1;
            e_addr = m_pc + 32'd4;
        end
        check("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) check("imem_addr", imem_addr, e_addr);
        check("ValidD", 32'(ValidD), 32'(m_valid));
        if (m_valid) begin
            check("InstrD", InstrD, m_instr);
            check("PCD", PCD, m_pcd);
            check("PCPlus4D", PCPlus4D, m_pcp4);
        end
        // Straight-line streaming right after reset: one fetch per cycle, valid from cycle 3.
        if (cyc <= early_n) begin
            check("early_addr", imem_addr, 32'(4 * (cyc - 1)));
            if (cyc >= 3) begin
                check("early_valid", 32'(ValidD), 32'd1);
                check("early_pcd", PCD, 32'(4 * (cyc - 3)));
            end
        end
        if (cyc <= 6) begin
            e_pc = RPC2 + 32'(4 * (cyc - 1));
            check("wrap_req", 32'(req2), 32'd1);
            check("wrap_addr", addr2, e_pc);
            if (cyc >= 3) begin
                e_pc = RPC2 + 32'(4 * (cyc - 3));
                check("wrap_valid", 32'(valid2), 32'd1);
                check("wrap_pcd", pcd2, e_pc);
                check("wrap_pcp4", pcp42, e_pc + 32'd4);
                check("wrap_instr", instr2, mdata(e_pc));
            end
        end
        if (imem_req && !req_seen) begin
            req_seen   = 1'b1;
            first_addr = imem_addr;
        end

        if (redir) begin
            m_pc = t; m_instr = NOP; m_valid = 1'b0; m_held = 1'b0;
            if (m_out && imem_rvalid) begin
                m_out = 1'b0; m_stale = 1'b0;
            end else if (m_out) begin
                m_stale = 1'b1;
            end
        end else if (m_held) begin
            if (!st) begin
                m_instr = m_buf; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_held = 1'b0;
            end
        end else if (!m_out || !imem_rvalid || m_stale) begin
            if (!m_out) m_out = 1'b1;
            else if (imem_rvalid) begin
                m_out = 1'b0; m_stale = 1'b0;
            end
            if (!st) m_valid = 1'b0;
        end else if (!st) begin
            m_instr = imem_rdata; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end else begin
            m_buf = imem_rdata; m_held = 1'b1; m_out = 1'b0;
        end

        if (imem_req) begin
            mem_busy = 1'b1;
            mem_cnt  = int'($urandom_range(lat_max, lat_min));
            mem_addr = imem_addr;
        end
        req2_q  = req2;
        addr2_q = addr2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        do_cycle(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        logic        st;
        logic [1:0]  src;
        reset_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; StallD = 1'b0;
        PCSrcE = 2'b00; PCTargetE = 32'd0; ALUResultE = 32'd0; Mtvec = 32'd0;
        rv2 = 1'b0; rd2 = 32'd0; req2_q = 1'b0; addr2_q = 32'd0;
        late_junk = 1'b0; req_seen = 1'b0; first_addr = 32'd0;
        lat_min = 1; lat_max = 1; early_n = 3;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr", InstrD, NOP);
        check("rst_pcd", PCD, 32'd0);
        check("rst_pcp4", PCPlus4D, 32'd0);
        check("rst_valid", 32'(ValidD), 32'd0);
        reset_n = 1'b1;

        // Stream from reset, then stall decode for 3 cycles as the response for PC 8 arrives.
        repeat (3) idle_cycle();
        early_n = 0;
        repeat (3) do_cycle(1'b1, 2'b00, 32'd0, 32'd0, 32'd0);
        idle_cycle();
        check("hold_instr", InstrD, mdata(32'd8));
        check("hold_pcd", PCD, 32'd8);
        check("hold_next_req", 32'(imem_req), 32'd1);
        check("hold_next_addr", imem_addr, 32'd12);

        // Random traffic.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            st  = ($urandom_range(9) < 3);
            src = ($urandom_range(9) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            do_cycle(st, src, $urandom, $urandom, $urandom);
        end

        // Redirect to 0x100 while a request is in flight; its response lands 2 cycles later.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !(mem_busy && mem_cnt == 3 && !m_stale); i++) idle_cycle();
        lat_min = 1; lat_max = 1;
        do_cycle(1'b0, 2'b01, 32'h0000_0100, 32'd0, 32'd0);
        for (int i = 0; i < 20 && !ValidD; i++) idle_cycle();
        check("redir_first_pcd", PCD, 32'h0000_0100);

        // jalr redirect together with a stall: the flush wins.
        for (int i = 0; i < 20 && !ValidD; i++) idle_cycle();
        req_seen = 1'b0;
        do_cycle(1'b1, 2'b10, 32'd0, 32'h0000_0205, 32'd0);
        check("jalr_instr", InstrD, NOP);
        check("jalr_valid", 32'(ValidD), 32'd0);
        for (int i = 0; i < 10 && !req_seen; i++) idle_cycle();
        check("jalr_req_seen", 32'(req_seen), 32'd1);
        check("jalr_next_addr", first_addr, 32'h0000_0204);

        // Trap redirect while a response is parked behind a stall.
        for (int i = 0; i < 20 && !(mem_busy && mem_cnt == 1 && !m_stale); i++) idle_cycle();
        do_cycle(1'b1, 2'b00, 32'd0, 32'd0, 32'd0);
        do_cycle(1'b1, 2'b00, 32'd0, 32'd0, 32'd0);
        req_seen = 1'b0;
        do_cycle(1'b0, 2'b11, 32'd0, 32'd0, 32'h8000_0003);
        for (int i = 0; i < 10 && !req_seen; i++) idle_cycle();
        check("trap_req_seen", 32'(req_seen), 32'd1);
        check("trap_next_addr", first_addr, 32'h8000_0000);

        // Reset in the middle of a request; the late response must be ignored.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !(mem_busy && mem_cnt == 3); i++) idle_cycle();
        #1 reset_n = 1'b0;
        #1;
        check("arst_instr", InstrD, NOP);
        check("arst_pcd", PCD, 32'd0);
        check("arst_pcp4", PCPlus4D, 32'd0);
        check("arst_valid", 32'(ValidD), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        lat_min = 1; lat_max = 1; late_junk = 1'b1; early_n = 3;
        repeat (8) idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the RV32I pipeline; sits directly upstream of the decode-stage controller.
- Holds the PC and issues requests to instruction memory, with one request outstanding at most.
- Drives the IF/ID pipeline register that the decoder reads (opcode/funct3/funct7 come from InstrD).
- Consumes the PCSrc redirect produced by the controller's branch logic, registered into execute as PCSrcE.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction placed in InstrD on reset and on flush (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- imem_req  output  1  request strobe; one cycle per request.
- imem_addr  output  32  request address, valid when imem_req=1.
- imem_rvalid  input  1  response valid; arrives at least 1 cycle after its request.
- imem_rdata  input  32  response instruction, valid with imem_rvalid.
- StallD  input  1  decode stalled; hold IF/ID.
- PCSrcE  input  2  00 sequential; 01 PCTargetE; 10 ALUResultE (jalr); 11 Mtvec.
- PCTargetE  input  32  branch/jal target.
- ALUResultE  input  32  jalr target.
- Mtvec  input  32  trap vector.
- InstrD  output  32  fetched instruction to decode.
- PCD  output  32  PC of InstrD.
- PCPlus4D  output  32  PCD+4.
- ValidD  output  1  InstrD is a real instruction.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is reset_n, asynchronous, active-low.
- Reset values: PCF=RESET_PC, state=IDLE, kill=0, buffer=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0. Reset mid-request abandons it; a late imem_rvalid arriving in IDLE after reset is ignored.
- redirect = (PCSrcE != 00).
- Redirect targets:
  - 01 → PCTargetE.
  - 10 → ALUResultE & ~32'h1.
  - 11 → Mtvec & ~32'h3.
- Redirect has the highest priority in every state.
- PC arithmetic: PCF+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- imem_req is combinational:
  - 1 in IDLE when no redirect.
  - 1 in WAIT on an accepted response when no redirect.
  - 0 otherwise.
- imem_addr = PCF in IDLE; PCF+4 in the WAIT-accept case. Value is don't-care when imem_req=0.
- IDLE:
  - no redirect: issue request at PCF → WAIT.
  - redirect: imem_req=0, PCF←target, flush IF/ID, stay IDLE.
- WAIT, imem_rvalid=0:
  - redirect: PCF←target, kill←1, flush IF/ID, stay WAIT.
  - no redirect: wait; IF/ID bubbles (ValidD←0) if StallD=0, holds if StallD=1.
- WAIT, imem_rvalid=1, kill=1: discard response, kill←0 → IDLE. A redirect this cycle also applies: PCF←target, flush.
- WAIT, imem_rvalid=1, redirect: discard response, PCF←target, flush, no new request → IDLE.
- WAIT, imem_rvalid=1, StallD=0, no redirect:
  - IF/ID load: InstrD←rdata, PCD←PCF, PCPlus4D←PCF+4, ValidD←1.
  - PCF←PCF+4.
  - issue next request at PCF+4, stay WAIT.
  - Sustained throughput is 1 instruction/cycle with 1-cycle memory.
- WAIT, imem_rvalid=1, StallD=1, no redirect: buffer←rdata → HOLD. IF/ID unchanged.
- HOLD:
  - StallD=1: hold.
  - StallD=0: load IF/ID from buffer (PCD=PCF), PCF←PCF+4 → IDLE.
  - redirect: drop buffer, PCF←target, flush → IDLE.
- Flush: InstrD←NOP_INSTR, ValidD←0; PCD/PCPlus4D don't-care. Flush overrides StallD.
- At most one outstanding request. kill guarantees no stale instruction ever reaches decode with ValidD=1.
- imem_rvalid in IDLE or HOLD is a protocol violation; the block ignores it.

Test Plan:
- Reset release, 1-cycle memory returning addr-derived data: imem_addr 0,4,8,… on consecutive cycles; ValidD=1 from 3rd cycle, PCD=0,4,8 with InstrD matching, PCPlus4D=PCD+4.
- StallD=1 for 3 cycles while response at PC=8 arrives: enter HOLD, InstrD/PCD frozen, no imem_req; on release InstrD=data(8), PCD=8, then a fetch at 12.
- Redirect PCSrcE=01, PCTargetE=0x100 while a request at 0x10 is outstanding, with the response 2 cycles later: that response is discarded (ValidD=0), the next request is at 0x100, and the first valid PCD=0x100.
- PCSrcE=10 with ALUResultE=0x205 and StallD=1 in the same cycle: InstrD=NOP, ValidD=0 (flush beats stall); next request at 0x204.
- PCSrcE=11 with Mtvec=0x8000_0003 in HOLD: buffer dropped; next fetch at 0x8000_0000.
- RESET_PC=32'hFFFF_FFFC: first PCD=0xFFFF_FFFC, PCPlus4D=0, next imem_addr=0. Separately, assert reset_n mid-WAIT: all outputs return to reset values asynchronously, and the late rvalid is ignored.
